// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    // One buffered fetch: the word and the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Instruction addresses are always word-aligned; low bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of the ROM, redirect and ID-side signals of the fetch unit.
// master = fetch unit, slave = its environment (ROM, EX, ID).
interface fetch_if;
    import fetch_pkg::*;

    logic [XLEN-1:0] i_address;
    logic            i_req;
    logic [XLEN-1:0] i_data_read;
    logic            i_data_valid;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr_data;
    logic [XLEN-1:0] instr_pc;
    logic            flush_pending;

    modport master (
        output i_address, i_req, instr_valid, instr_data, instr_pc, flush_pending,
        input  i_data_read, i_data_valid, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  i_address, i_req, instr_valid, instr_data, instr_pc, flush_pending,
        output i_data_read, i_data_valid, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries with push/pop/flush and an occupancy count.
// Push and pop may coincide when full or empty; flush wins over both.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wr_entry,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage write.
    // NOTE: the data array has no reset; count and pointers decide what is valid,
    // so resetting it would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

    // Pointer and occupancy update.
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A push into a full FIFO without a matching pop means the credit rule broke.
    assert property (@(posedge clk) disable iff (reset) !(push && !do_push && !flush))
        else $error("fetch_fifo overflow push");

endmodule

// File: rtl/fetch_unit.sv
// Credit-based instruction prefetcher: in-order ROM requests, FIFO buffering,
// valid/ready delivery to ID, and redirect handling that discards stale words.
// Optional FETCH_BYPASS_EN: a response arriving into an empty FIFO is shown to
// ID in the same cycle and skips the FIFO when ID takes it.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
    input logic    clk,
    input logic    reset,
    fetch_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    fetch_entry_t    head;
    fetch_entry_t    resp_entry;
    logic            fifo_valid;
    logic            req;
    logic            keep;
    logic            bypass;
    logic            push;
    logic            pop;

    // Credits: buffered words plus words still on their way may not exceed the FIFO.
    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign req         = !reset && !bus.redirect_valid && (credit_used < (CW + 1)'(FIFO_DEPTH));
    assign keep        = bus.i_data_valid && (discard == '0) && !bus.redirect_valid;
    assign fifo_valid  = (count != '0);
    assign resp_entry  = '{pc: resp_pc, instr: bus.i_data_read};

`ifdef FETCH_BYPASS_EN
    assign bypass = keep && !fifo_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push = keep && !(bypass && bus.instr_ready);
    assign pop  = fifo_valid && bus.instr_ready;

    assign bus.i_req         = req;
    assign bus.i_address     = fetch_pc;
    assign bus.flush_pending = (discard != '0);

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (bus.redirect_valid),
        .wr_entry (resp_entry),
        .head     (head),
        .count    (count)
    );

    // ID-side view: FIFO head first, then a bypassed response, else idle values.
    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        bus.instr_valid = fifo_valid || bypass;
        bus.instr_data  = '0;
        bus.instr_pc    = resp_pc;
        if (fifo_valid) begin
            bus.instr_data = head.instr;
            bus.instr_pc   = head.pc;
        end else if (bypass) begin
            bus.instr_data = bus.i_data_read;
            bus.instr_pc   = resp_pc;
        end
    end

    // Request/response bookkeeping and redirect handling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            case ({req, bus.i_data_valid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            if (bus.redirect_valid) begin
                // Everything still in flight is stale, minus a word landing right now.
                discard  <= outstanding - CW'(bus.i_data_valid);
                fetch_pc <= word_align(bus.redirect_pc);
                resp_pc  <= word_align(bus.redirect_pc);
            end else begin
                if (req)  fetch_pc <= fetch_pc + XLEN'(4);
                if (keep) resp_pc  <= resp_pc + XLEN'(4);
                if (bus.i_data_valid && (discard != '0)) discard <= discard - CW'(1);
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the pipelined RISC-V core. It replaces the free-running PC+4 counter with a credit-based prefetcher.
- Issues in-order requests to the instruction ROM and tolerates variable ROM latency.
- Buffers returned words with their PC in a FIFO.
- Presents them to ID over a valid/ready handshake.
- Handles EX-stage redirects (branch/jump/JALR) by flushing the FIFO and discarding in-flight stale responses. This removes the NOP-injection hack in the core.

Parameters:
XLEN, 32, address/instruction width
FIFO_DEPTH, 4, prefetch FIFO entries; also caps requests in flight (≥2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
i_address  out  XLEN  ROM fetch address, word-aligned
i_req  out  1  fetch request this cycle; ROM accepts every asserted cycle
i_data_read  in  XLEN  ROM read data
i_data_valid  in  1  ROM response strobe; in request order, max one per cycle
redirect_valid  in  1  EX redirect strobe, single cycle
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (forced 00)
instr_valid  out  1  FIFO head valid to ID
instr_ready  in  1  ID accepts head
instr_data  out  XLEN  head instruction
instr_pc  out  XLEN  head PC
flush_pending  out  1  stale responses still being discarded

Interface rule: one clock; reset is asynchronous and active-high. Ports are clk and reset.

Behaviour:
- Reset values (async assert):
  - fetch_pc=resp_pc=RESET_PC.
  - outstanding=discard=0; FIFO empty.
  - i_req=0, instr_valid=0, instr_data=0, instr_pc=RESET_PC, flush_pending=0.
  - Reset mid-operation drops everything. The ROM is reset by the same signal, so no late responses arrive.
- Counters outstanding, discard and count are $clog2(FIFO_DEPTH+1) bits wide.
- i_address = fetch_pc (registered). i_req = !redirect_valid && (count + outstanding < FIFO_DEPTH).
- Request accepted (i_req=1): fetch_pc += 4 (mod 2^XLEN wrap), outstanding++.
- Response (i_data_valid=1): outstanding--.
  - If discard>0: discard--, word dropped.
  - Else: push {resp_pc, i_data_read}, resp_pc += 4.
  - Push never overflows, guaranteed by the credit rule. An overflow push is an assertion failure.
- Request and response in the same cycle: outstanding unchanged.
- Pop: instr_valid && instr_ready. instr_valid = count != 0. Push and pop in the same cycle are allowed when full or empty.
- Redirect cycle N:
  - i_req=0.
  - A pop in cycle N completes normally; the FIFO is then cleared.
  - Any response in cycle N is dropped.
  - discard <= outstanding minus (1 if response in N).
  - fetch_pc=resp_pc <= {redirect_pc[XLEN-1:2],2'b00}.
- Redirect during flush_pending: discard is recomputed as above, which absorbs the earlier stale words.
- flush_pending = discard != 0.
- Timing with ROM latency 1:
  - Redirect at N → request at N+1 → response at N+2 → instr_valid at N+3.
  - Steady state: one instruction per cycle while instr_ready=1.
- Stall: instr_ready=0 fills the FIFO. i_req drops when count+outstanding == FIFO_DEPTH and resumes the cycle after a pop.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when FIFO empty, discard=0, i_data_valid=1 and no redirect, instr_valid/instr_data/instr_pc are driven combinationally from the response.
  - If instr_ready=1, the word is not pushed, saving one cycle (N+2 in the example above).
  - If instr_ready=0, the word is pushed as normal.
- Undefined: every response goes through the FIFO, giving a minimum of one cycle response-to-instr_valid.

Decomposition:
- Package fetch_pkg holds:
  - localparam XLEN and INSTR_NOP = 32'h0000_0013.
  - typedef struct packed fetch_entry_t {pc, instr}.
  - The function for the word-align mask.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, parametrised depth, with push/pop/flush, count output and async active-high reset.
- The credit/discard control lives in fetch_unit.

Test Plan:
1. Reset, ROM latency 1, instr_ready=1:
   - i_address sequence 0,4,8,...
   - instr_pc 0,4,8 on consecutive cycles after the first at cycle 3 (cycle 2 with FETCH_BYPASS_EN).
2. instr_ready=0 for 10 cycles, FIFO_DEPTH=4:
   - Exactly 4 requests issued, then i_req=0.
   - On instr_ready=1, pcs 0..12 pop in order and i_req resumes the next cycle.
3. ROM latency 3, three requests outstanding, redirect_pc=0x100:
   - Three stale responses dropped; flush_pending high until the third.
   - First instr_pc=0x100.
4. Second redirect to 0x200 while discard=2, with a response in the same cycle:
   - Correct stale count dropped; first delivered pc=0x200.
5. redirect_pc=0x103: fetch begins at 0x100. fetch_pc=0xFFFF_FFFC then +4 → i_address wraps to 0x0.
6. Assert reset mid-stream with a full FIFO: all outputs return to reset values asynchronously; fetch restarts at RESET_PC.
